// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: opcode constants used by fetch and the PC/branch logic,
// FSM state encoding and the buffered {pc, instr} entry layout.
package fetch_unit_pkg;

    localparam logic [3:0] OPCODE_B   = 4'hC;
    localparam logic [3:0] OPCODE_BR  = 4'hD;
    localparam logic [3:0] OPCODE_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_entry_t;

    // Sequential fetch step; wraps 16'hFFFE to 16'h0000.
    function automatic logic [15:0] add_two(input logic [15:0] addr);
        return addr + 16'd2;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small instruction buffer holding {pc, instr} entries between fetch and decode.
// Clear has priority over push and pop.
module instr_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign do_push = push_i && (count_q != (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates everything that reads it.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding read to a variable-latency memory,
// buffered hand-off to decode, flush on redirect, stop after HLT.
//
// state  | meaning
// IDLE   | no read in flight; issue when a buffer slot is free
// WAIT   | read in flight; its response is pushed into the buffer
// DRAIN  | read in flight after a redirect; its response is discarded
// HALTED | HLT fetched; no requests until redirect or reset
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [15:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [15:0] instr_o,
    output logic [15:0] instr_pc_o,
    input  logic        decode_ready_i,
    output logic        halted_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e   state_q, state_d;
    logic [15:0]    fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] fifo_count;
    logic           fifo_empty, fifo_push, fifo_pop, fifo_clear;
    logic           can_issue;
    fetch_entry_t   push_entry, head_entry;

    assign can_issue = (fifo_count < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            ST_IDLE:   if (!redirect_i && can_issue) state_d = ST_WAIT;
            ST_WAIT: begin
                if (redirect_i)
                    state_d = mem_rvalid_i ? ST_IDLE : ST_DRAIN;
                else if (mem_rvalid_i)
                    state_d = (mem_rdata_i[15:12] == OPCODE_HLT) ? ST_HALTED : ST_IDLE;
            end
            ST_DRAIN:  if (mem_rvalid_i) state_d = ST_IDLE;
            ST_HALTED: if (redirect_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (redirect_i)
            fetch_pc_d = redirect_pc_i;
        else if (state_q == ST_WAIT && mem_rvalid_i)
            fetch_pc_d = add_two(fetch_pc_q);
    end

    // A request is never raised while reset is held, so nothing leaks out before release.
    always_comb begin
        mem_req_o  = 1'b0;
        fifo_push  = 1'b0;
        fifo_clear = redirect_i;
        fifo_pop   = !fifo_empty && decode_ready_i;
        if (state_q == ST_IDLE && rst_n_i && !redirect_i && can_issue) mem_req_o = 1'b1;
        if (state_q == ST_WAIT && mem_rvalid_i && !redirect_i) fifo_push = 1'b1;
    end

    assign mem_addr_o       = fetch_pc_q;
    assign halted_o         = (state_q == ST_HALTED);
    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.instr = mem_rdata_i;

    instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = head_entry.instr;
    assign instr_pc_o    = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0x0000 and 0xFFFE),
// each fed by a simple fixed-latency memory responder.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // instance A: RESET_PC = 0x0000
    logic        rst_n = 1'b0, redirect = 1'b0, mem_rvalid, decode_ready = 1'b1;
    logic [15:0] redirect_pc = 16'h0000, mem_rdata;
    logic        mem_req, instr_valid, halted;
    logic [15:0] mem_addr, instr, instr_pc;
    // instance B: RESET_PC = 0xFFFE
    logic        rst_n_b = 1'b0, redirect_b = 1'b0, mem_rvalid_b, decode_ready_b = 1'b1;
    logic [15:0] redirect_pc_b = 16'h0000, mem_rdata_b;
    logic        mem_req_b, instr_valid_b, halted_b;
    logic [15:0] mem_addr_b, instr_b, instr_pc_b;

    logic [15:0] halt_addr = 16'h0001;
    int lat_a = 1, lat_b = 1;

    fetch_unit #(.FIFO_DEPTH(2), .RESET_PC(16'h0000)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .instr_valid_o(instr_valid), .instr_o(instr),
        .instr_pc_o(instr_pc), .decode_ready_i(decode_ready), .halted_o(halted));

    fetch_unit #(.FIFO_DEPTH(2), .RESET_PC(16'hFFFE)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n_b), .redirect_i(redirect_b), .redirect_pc_i(redirect_pc_b),
        .mem_req_o(mem_req_b), .mem_addr_o(mem_addr_b), .mem_rvalid_i(mem_rvalid_b),
        .mem_rdata_i(mem_rdata_b), .instr_valid_o(instr_valid_b), .instr_o(instr_b),
        .instr_pc_o(instr_pc_b), .decode_ready_i(decode_ready_b), .halted_o(halted_b));

    function automatic logic [15:0] mem_word(input logic [15:0] a, input logic [15:0] h);
        return (a == h) ? 16'hF000 : {4'h1, a[11:0]};
    endfunction

    // Memory responders: request seen in cycle t -> rvalid during cycle t+lat.
    bit pend_a = 0, pend_b = 0;
    int cnt_a = 0, cnt_b = 0;
    logic [15:0] paddr_a = 16'h0, paddr_b = 16'h0;

    initial begin
        mem_rvalid = 1'b0; mem_rdata = 16'h0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            if (pend_a) begin
                cnt_a--;
                if (cnt_a <= 0) begin mem_rvalid = 1'b1; mem_rdata = mem_word(paddr_a, halt_addr); pend_a = 0; end
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (mem_req === 1'b1) begin pend_a = 1; cnt_a = lat_a; paddr_a = mem_addr; end
    end

    initial begin
        mem_rvalid_b = 1'b0; mem_rdata_b = 16'h0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid_b = 1'b0;
            if (pend_b) begin
                cnt_b--;
                if (cnt_b <= 0) begin mem_rvalid_b = 1'b1; mem_rdata_b = mem_word(paddr_b, 16'h0001); pend_b = 0; end
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (mem_req_b === 1'b1) begin pend_b = 1; cnt_b = lat_b; paddr_b = mem_addr_b; end
    end

    // Returns at the start of the first cycle after reset release.
    task automatic reset_a();
        rst_n = 1'b0; redirect = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic reset_b();
        rst_n_b = 1'b0; redirect_b = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n_b = 1'b1;
    endtask

    task automatic wait_req_a(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_n_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_instr_valid: got %b expected 0", instr_valid); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b expected 0", halted); end
        n_tests++; if (mem_req_b !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_b: got %b expected 0", mem_req_b); end
    endtask

    task automatic test_stream();
        bit ok;
        lat_a = 1; decode_ready = 1'b1; halt_addr = 16'h0001;
        reset_a();
        wait_req_a(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stream_first_req: got timeout expected mem_req"); end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req%0d: got %b expected 1", k, mem_req); end
            n_tests++; if (mem_addr !== 16'(2*k)) begin n_fail++; $display("FAIL stream_addr%0d: got %h expected %h", k, mem_addr, 16'(2*k)); end
            @(negedge clk);
            n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid%0d: got %b expected 0", k, instr_valid); end
            @(negedge clk);
            n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d: got %b expected 1", k, instr_valid); end
            n_tests++; if (instr_pc !== 16'(2*k)) begin n_fail++; $display("FAIL stream_pc%0d: got %h expected %h", k, instr_pc, 16'(2*k)); end
            n_tests++; if (instr !== {4'h1, 12'(2*k)}) begin n_fail++; $display("FAIL stream_instr%0d: got %h expected %h", k, instr, {4'h1, 12'(2*k)}); end
        end
    endtask

    task automatic test_backpressure();
        int reqs = 0;
        lat_a = 1; decode_ready = 1'b0;
        reset_a();
        repeat (12) begin @(negedge clk); if (mem_req === 1'b1) reqs++; end
        n_tests++; if (reqs != 2) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 2", reqs); end
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", instr_valid); end
        n_tests++; if (instr_pc !== 16'h0000) begin n_fail++; $display("FAIL bp_head_pc: got %h expected 0000", instr_pc); end
        @(posedge clk); #1 decode_ready = 1'b1;
        @(posedge clk); #1 decode_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL bp_req_after_pop: got %b expected 1", mem_req); end
        n_tests++; if (mem_addr !== 16'h0004) begin n_fail++; $display("FAIL bp_addr_after_pop: got %h expected 0004", mem_addr); end
        n_tests++; if (instr_pc !== 16'h0002) begin n_fail++; $display("FAIL bp_next_head: got %h expected 0002", instr_pc); end
        decode_ready = 1'b1;
    endtask

    task automatic test_redirect_wait();
        int bad = 0;
        bit found = 0;
        lat_a = 3; decode_ready = 1'b1;
        reset_a();
        @(negedge clk);
        n_tests++; if (mem_addr !== 16'h0000 || mem_req !== 1'b1) begin n_fail++; $display("FAIL rw_first_req: got %b/%h expected 1/0000", mem_req, mem_addr); end
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'h0040;
        @(posedge clk); #1 redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) bad++;
            if (mem_req === 1'b1) begin found = 1; break; end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL rw_req_timeout: got none expected mem_req"); end
        n_tests++; if (mem_addr !== 16'h0040) begin n_fail++; $display("FAIL rw_addr: got %h expected 0040", mem_addr); end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rw_stale_valid: got %0d expected 0", bad); end
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (instr_valid === 1'b1) break; end
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rw_valid: got %b expected 1", instr_valid); end
        n_tests++; if (instr_pc !== 16'h0040) begin n_fail++; $display("FAIL rw_pc: got %h expected 0040", instr_pc); end
        n_tests++; if (instr !== 16'h1040) begin n_fail++; $display("FAIL rw_instr: got %h expected 1040", instr); end
    endtask

    task automatic test_redirect_rvalid_pop();
        lat_a = 1; decode_ready = 1'b0;
        reset_a();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b1 || mem_addr !== 16'h0002) begin n_fail++; $display("FAIL rrp_pre: got %b/%h expected 1/0002", instr_valid, mem_addr); end
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'h0080; decode_ready = 1'b1;
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rrp_flush: got %b expected 0", instr_valid); end
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rrp_req: got %b expected 1", mem_req); end
        n_tests++; if (mem_addr !== 16'h0080) begin n_fail++; $display("FAIL rrp_addr: got %h expected 0080", mem_addr); end
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0080) begin n_fail++; $display("FAIL rrp_next: got %b/%h expected 1/0080", instr_valid, instr_pc); end
    endtask

    task automatic test_halt();
        int reqs = 0;
        int quiet = 0;
        lat_a = 1; decode_ready = 1'b1; halt_addr = 16'h0006;
        reset_a();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) reqs++;
            if (halted === 1'b1) break;
        end
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b expected 1", halted); end
        n_tests++; if (reqs != 4) begin n_fail++; $display("FAIL halt_req_count: got %0d expected 4", reqs); end
        repeat (10) begin @(negedge clk); if (mem_req === 1'b1) quiet++; end
        n_tests++; if (quiet != 0) begin n_fail++; $display("FAIL halt_quiet: got %0d expected 0", quiet); end
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'h0010;
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b expected 0", halted); end
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010) begin n_fail++; $display("FAIL halt_resume: got %b/%h expected 1/0010", mem_req, mem_addr); end
        halt_addr = 16'h0001;
    endtask

    task automatic test_wrap_reset();
        lat_b = 1; decode_ready_b = 1'b1;
        reset_b();
        @(negedge clk);
        n_tests++; if (mem_req_b !== 1'b1 || mem_addr_b !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_first: got %b/%h expected 1/fffe", mem_req_b, mem_addr_b); end
        @(posedge clk); #1 lat_b = 3;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (mem_req_b !== 1'b1 || mem_addr_b !== 16'h0000) begin n_fail++; $display("FAIL wrap_second: got %b/%h expected 1/0000", mem_req_b, mem_addr_b); end
        n_tests++; if (instr_valid_b !== 1'b1 || instr_pc_b !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_head: got %b/%h expected 1/fffe", instr_valid_b, instr_pc_b); end
        @(posedge clk); #1 rst_n_b = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n_b = 1'b1;
        @(negedge clk);
        n_tests++; if (mem_req_b !== 1'b1 || mem_addr_b !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_rst_req: got %b/%h expected 1/fffe", mem_req_b, mem_addr_b); end
        @(negedge clk);
        n_tests++; if (instr_valid_b !== 1'b0) begin n_fail++; $display("FAIL wrap_stale: got %b expected 0", instr_valid_b); end
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (instr_valid_b === 1'b1) break; end
        n_tests++; if (instr_valid_b !== 1'b1 || instr_pc_b !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_new_pc: got %b/%h expected 1/fffe", instr_valid_b, instr_pc_b); end
        n_tests++; if (instr_b !== 16'h1FFE) begin n_fail++; $display("FAIL wrap_new_instr: got %h expected 1ffe", instr_b); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid_pop();
        test_halt();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
